// File: rtl/mem_sched_pkg.sv
// Shared state encoding and sizing helper for the memory request scheduler.
package mem_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WDATA = 2'd2;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational N-way round-robin picker.
// Searches upward from last+1 with wrap.
module rr_priority_picker
  import mem_sched_pkg::*;
#(
  parameter int NUM_APPS = 4,
  localparam int ID_W = id_width(NUM_APPS)
) (
  input  logic [NUM_APPS-1:0] req,
  input  logic [ID_W-1:0]     last,
  output logic [NUM_APPS-1:0] gnt,
  output logic [ID_W-1:0]     idx
);

  logic [2*NUM_APPS-1:0] dbl;
  logic [NUM_APPS-1:0]   rot;
  int                    pos;

  assign dbl = {req, req};

  // rot[0] is the requester right after last
  always_comb begin
    rot = dbl[(int'(last) + 1) +: NUM_APPS];
    pos = 0;
    for (int i = NUM_APPS - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    idx = ID_W'((int'(last) + 1 + pos) % NUM_APPS);
    gnt = '0;
    if (|req) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Shares one memory request/write-data channel among NUM_APPS requesters.
// Round-robin grant; a write owns the channel until its last beat.
module mem_req_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_APPS = 4,
  parameter int ADDR_W   = 64,
  parameter int LEN_W    = 8,
  parameter int DATA_W   = 512,
  localparam int ID_W = id_width(NUM_APPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_APPS-1:0]        app_req_valid,
  input  logic [NUM_APPS-1:0]        app_req_write,
  input  logic [NUM_APPS*ADDR_W-1:0] app_req_addr,
  input  logic [NUM_APPS*LEN_W-1:0]  app_req_len,
  output logic [NUM_APPS-1:0]        app_req_ready,
  input  logic [NUM_APPS-1:0]        app_wr_valid,
  input  logic [NUM_APPS*DATA_W-1:0] app_wr_data,
  output logic [NUM_APPS-1:0]        app_wr_ready,
  output logic                       mem_req_valid,
  output logic                       mem_req_write,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [LEN_W-1:0]           mem_req_len,
  output logic [ID_W-1:0]            mem_req_app_id,
  input  logic                       mem_req_ready,
  output logic                       mem_wr_valid,
  output logic [DATA_W-1:0]          mem_wr_data,
  output logic                       mem_wr_last,
  input  logic                       mem_wr_ready
);

  state_t              state;
  logic [ID_W-1:0]     last_serviced;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     win_idx;
  logic [NUM_APPS-1:0] win_gnt;
  logic [LEN_W-1:0]    beat_cnt;
  logic                beat_hs;

  rr_priority_picker #(
    .NUM_APPS(NUM_APPS)
  ) u_pick (
    .req (app_req_valid),
    .last(last_serviced),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign app_req_ready  = (state == IDLE && !rst) ? win_gnt : '0;
  assign mem_req_valid  = (state == ISSUE);
  assign mem_req_app_id = owner;

  assign mem_wr_valid = (state == WDATA) && app_wr_valid[owner];
  assign mem_wr_last  = (state == WDATA) && (beat_cnt == '0);
  assign mem_wr_data  = (state == WDATA) ?
                        app_wr_data[owner*DATA_W +: DATA_W] : '0;
  assign beat_hs      = mem_wr_valid && mem_wr_ready;

  always_comb begin
    app_wr_ready = '0;
    if (state == WDATA) app_wr_ready[owner] = mem_wr_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_serviced <= ID_W'(NUM_APPS - 1);
      owner         <= '0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_len   <= '0;
      beat_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|app_req_valid) begin
            mem_req_write <= app_req_write[win_idx];
            mem_req_addr  <= app_req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_req_len   <= app_req_len[win_idx*LEN_W +: LEN_W];
            owner         <= win_idx;
            last_serviced <= win_idx;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state    <= mem_req_write ? WDATA : IDLE;
            beat_cnt <= mem_req_write ? mem_req_len : '0;
          end
        end
        WDATA: begin
          if (beat_hs) begin
            if (beat_cnt == '0) state <= IDLE;
            else beat_cnt <= beat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Self-checking bench for mem_req_scheduler.
// Transaction-level round-robin model with directed and random steps.
module tb_mem_req_scheduler;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int LW = 8;
  localparam int DW = 512;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    app_req_valid, app_req_write, app_req_ready;
  logic [N*AW-1:0] app_req_addr;
  logic [N*LW-1:0] app_req_len;
  logic [N-1:0]    app_wr_valid, app_wr_ready;
  logic [N*DW-1:0] app_wr_data;
  logic            mem_req_valid, mem_req_write, mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic [LW-1:0]   mem_req_len;
  logic [IW-1:0]   mem_req_app_id;
  logic            mem_wr_valid, mem_wr_last, mem_wr_ready;
  logic [DW-1:0]   mem_wr_data;

  int checks = 0;
  int errors = 0;
  int m_last = N - 1;
  int wr_mode = 0;

  always #5 clk = ~clk;

  mem_req_scheduler #(
    .NUM_APPS(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .app_req_valid(app_req_valid), .app_req_write(app_req_write),
    .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_ready(app_req_ready),
    .app_wr_valid(app_wr_valid), .app_wr_data(app_wr_data),
    .app_wr_ready(app_wr_ready),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_req_app_id(mem_req_app_id), .mem_req_ready(mem_req_ready),
    .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data),
    .mem_wr_last(mem_wr_last), .mem_wr_ready(mem_wr_ready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] bdata(input int a, input int b);
    return {(DW/32){32'(a * 1000 + b)}};
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends one cycle after a rising edge, with the DUT idle.
  task automatic txn(input logic [N-1:0] mask, input int stall,
                     input bit keep, input int abort_at);
    int w, beats, cyc, budget;
    logic wr;
    logic [LW-1:0] ln;
    logic [AW-1:0] ad;
    logic [N-1:0] vmask;
    logic [4:0] pat;
    pat = 5'b11101;
    app_req_valid = mask;
    @(negedge clk);
    w = rr(mask, m_last);
    chk("grant", app_req_ready, onehot(w));
    chk("idle_no_req", mem_req_valid, 0);
    wr = app_req_write[w];
    ln = app_req_len[w*LW +: LW];
    ad = app_req_addr[w*AW +: AW];
    m_last = w;
    step();
    if (!keep) app_req_valid[w] = 1'b0;
    mem_req_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, ad);
      chk("stall_len", mem_req_len, ln);
      chk("stall_rdy0", app_req_ready, 0);
      step();
      if (s == stall - 1) mem_req_ready = 1'b1;
    end
    @(negedge clk);
    chk("req_valid", mem_req_valid, 1);
    chk("req_write", mem_req_write, wr);
    chk("req_addr", mem_req_addr, ad);
    chk("req_len", mem_req_len, ln);
    chk("req_id", mem_req_app_id, w);
    chk("issue_rdy0", app_req_ready, 0);
    step();
    mem_req_ready = 1'b0;
    if (wr) begin
      beats = 0;
      cyc = 0;
      budget = 4 * (int'(ln) + 1) + 20;
      while (beats <= int'(ln) && cyc < budget && beats != abort_at) begin
        if (wr_mode == 1) begin
          vmask = N'($urandom);
          vmask[w] = ($urandom_range(3) != 0);
          app_wr_valid = vmask;
          mem_wr_ready = ($urandom_range(3) != 0);
        end else begin
          app_wr_valid = '1;
          mem_wr_ready = (wr_mode == 2) ? pat[cyc % 5] : 1'b1;
        end
        for (int a = 0; a < N; a++) app_wr_data[a*DW +: DW] = bdata(a, beats);
        @(negedge clk);
        chk("wr_valid", mem_wr_valid, app_wr_valid[w]);
        chk("wr_ready", app_wr_ready, mem_wr_ready ? onehot(w) : '0);
        if (app_wr_valid[w]) begin
          chk("wr_data", mem_wr_data, bdata(w, beats));
          chk("wr_last", mem_wr_last, beats == int'(ln));
        end
        if (app_wr_valid[w] && mem_wr_ready) beats++;
        step();
        cyc++;
      end
      if (abort_at < 0) chk("beat_count", beats, int'(ln) + 1);
      app_wr_valid = '0;
      mem_wr_ready = 1'b0;
    end
  endtask

  task automatic set_app(input int a, input logic w, input logic [LW-1:0] l,
                         input logic [AW-1:0] ad);
    app_req_write[a] = w;
    app_req_len[a*LW +: LW] = l;
    app_req_addr[a*AW +: AW] = ad;
  endtask

  initial begin
    rst = 1'b1;
    app_req_valid = '0;
    app_req_write = '0;
    app_req_addr = '0;
    app_req_len = '0;
    app_wr_valid = '0;
    app_wr_data = '0;
    mem_req_ready = 1'b0;
    mem_wr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", app_req_ready, 0);
    chk("rst_wr_ready", app_wr_ready, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_len", mem_req_len, 0);
    chk("rst_id", mem_req_app_id, 0);
    chk("rst_wr_valid", mem_wr_valid, 0);
    step();

    // four readers, all valid: order 0,1,2,3,0
    for (int a = 0; a < N; a++) set_app(a, 1'b0, LW'(a), AW'(64'h1000 * (a + 1)));
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 0, 1'b1, -1);
      chk("rr_order", m_last, i % N);
    end
    app_req_valid = '0;

    // app 2 write len 3 with toggling memory ready
    set_app(2, 1'b1, 8'd3, 64'hABCD_0000_0000_2000);
    wr_mode = 2;
    txn(4'b0100, 0, 1'b0, -1);
    wr_mode = 0;

    // stalled issue while app 2 also waits
    set_app(1, 1'b0, 8'd5, 64'h1111_2222_3333_4444);
    set_app(2, 1'b0, 8'd1, 64'h5555_6666_7777_8888);
    txn(4'b0110, 5, 1'b0, -1);
    txn(4'b0100, 0, 1'b0, -1);

    // len 0 write from app 3, then app 0 wins over app 3
    set_app(3, 1'b1, 8'd0, 64'h3);
    set_app(0, 1'b0, 8'd0, 64'h40);
    txn(4'b1000, 0, 1'b0, -1);
    txn(4'b1001, 0, 1'b0, -1);
    chk("after_len0", m_last, 0);
    app_req_valid = '0;

    // reset after 2 of 8 beats
    set_app(0, 1'b1, 8'd7, 64'hDEAD);
    txn(4'b0001, 0, 1'b0, 2);
    app_req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", app_req_ready, 0);
    chk("mid_rst_wr_ready", app_wr_ready, 0);
    chk("mid_rst_req_valid", mem_req_valid, 0);
    chk("mid_rst_write", mem_req_write, 0);
    chk("mid_rst_addr", mem_req_addr, 0);
    chk("mid_rst_len", mem_req_len, 0);
    chk("mid_rst_id", mem_req_app_id, 0);
    chk("mid_rst_wr_valid", mem_wr_valid, 0);
    chk("mid_rst_wr_last", mem_wr_last, 0);
    step();
    m_last = N - 1;
    set_app(0, 1'b0, 8'd0, 64'h77);
    set_app(1, 1'b0, 8'd2, 64'h88);
    txn(4'b0011, 0, 1'b0, -1);
    txn(4'b0010, 0, 1'b0, -1);
    app_req_valid = '0;

    // maximum length write
    set_app(1, 1'b1, 8'd255, 64'hFFFF_0000);
    txn(4'b0010, 0, 1'b0, -1);

    // random traffic
    wr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] m;
      for (int a = 0; a < N; a++) begin
        set_app(a, 1'($urandom), LW'($urandom_range(6)),
                {32'($urandom), 32'($urandom)});
      end
      m = N'($urandom);
      if (m == '0) m = onehot($urandom_range(N - 1));
      txn(m, $urandom_range(2), 1'b0, -1);
      app_req_valid = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
